// File: rtl/led_bar_sequencer_if.sv
// Table-write, run-configuration and status bundle for led_bar_sequencer.
// master drives the table and run settings and observes the bar; slave is the sequencer.
interface led_bar_sequencer_if #(
    parameter int N_LED = 16,
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
);
    localparam int LW = $clog2(N_LED + 1);
    localparam int IW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [LW-1:0]    wr_data;
    logic [IW-1:0]    seq_len;
    logic [DIV_W-1:0] step_div;
    logic [N_LED-1:0] led;
    logic [LW-1:0]    level;
    logic [1:0]       state;
    logic [IW-1:0]    index;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data, seq_len, step_div,
        input  led, level, state, index, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, seq_len, step_div,
        output led, level, state, index, done
    );
endinterface

// File: rtl/led_bar_sequencer.sv
// Thermometer LED bar that walks a waypoint table one step per prescaler tick after a push-button flick.
// Flick acts 3 clk after it is seen high; HOLD takes 1 clk per waypoint; no backpressure, done is a 1-clk pulse.
module led_bar_sequencer #(
    parameter int N_LED = 16,
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flick,
    led_bar_sequencer_if.slave bus
);
    localparam int LW = $clog2(N_LED + 1);
    localparam int IW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RISE = 2'b01;
    localparam logic [1:0] S_FALL = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;

    localparam logic [LW-1:0] LVL_MAX  = LW'(N_LED);
    localparam logic [LW-1:0] LVL_HALF = LW'(N_LED / 2);
    localparam logic [IW-1:0] LEN_MAX  = IW'(DEPTH);

    function automatic logic [LW-1:0] tbl_rst(input int i);
        case (i)
            0, 2:    tbl_rst = LVL_MAX;
            1, 4:    tbl_rst = LVL_HALF;
            default: tbl_rst = '0;
        endcase
    endfunction

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             edge_q, edge_d;
    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [IW-1:0]    index_q, index_d;
    logic [IW-1:0]    len_q, len_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LW-1:0]    tbl_q [DEPTH];
    logic [LW-1:0]    tbl_d [DEPTH];

    logic             flick_evt;
    logic             tick;
    logic [LW-1:0]    target;
    logic [N_LED-1:0] led_w;

    assign flick_evt = sync2_q & ~edge_q;
    assign tick      = (cnt_q == div_q);
    assign target    = tbl_q[index_q[AW-1:0]];

    always_comb begin
        sync1_d = flick;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        state_d = state_q;
        level_d = level_q;
        index_d = index_q;
        len_d   = len_q;
        done_d  = 1'b0;
        tbl_d   = tbl_q;

        case (state_q)
            S_IDLE: begin
                // the write lands before the run's first HOLD reads the table
                if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) begin
                    tbl_d[bus.wr_addr] = (bus.wr_data > LVL_MAX) ? LVL_MAX : bus.wr_data;
                end
                if (flick_evt) begin
                    len_d = (bus.seq_len > LEN_MAX) ? LEN_MAX : bus.seq_len;
                    if (len_d == '0) begin
                        done_d = 1'b1;
                    end else begin
                        index_d = '0;
                        level_d = '0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (index_q >= len_q) begin
                    state_d = S_IDLE;
                    level_d = '0;
                    index_d = '0;
                    done_d  = 1'b1;
                end else if (target > level_q) begin
                    state_d = S_RISE;
                end else if (target < level_q) begin
                    state_d = S_FALL;
                end else begin
                    index_d = index_q + IW'(1);
                end
            end
            S_RISE: begin
                if (tick) begin
                    level_d = level_q + LW'(1);
                    if (level_d == target) begin
                        index_d = index_q + IW'(1);
                        state_d = S_HOLD;
                    end
                end
            end
            default: begin
                // a flick while falling backs up one waypoint and re-climbs from here
                if (flick_evt && (index_q != '0)) begin
                    index_d = index_q - IW'(1);
                    state_d = S_HOLD;
                end else if (tick) begin
                    level_d = level_q - LW'(1);
                    if (level_d == target) begin
                        index_d = index_q + IW'(1);
                        state_d = S_HOLD;
                    end
                end
            end
        endcase
    end

    // step_div is only picked up when the count restarts, so a mid-run change lands at a wrap
    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        div_d = div_q;
        if ((state_q == S_IDLE) || tick ||
            ((state_d != S_IDLE) && (state_d != state_q))) begin
            cnt_d = '0;
            div_d = bus.step_div;
        end
    end

    always_comb begin
        led_w = '0;
        for (int i = 0; i < N_LED; i++) begin
            led_w[i] = (i < int'(level_q));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            state_q <= S_IDLE;
            level_q <= '0;
            index_q <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= tbl_rst(i);
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            state_q <= state_d;
            level_q <= level_d;
            index_q <= index_d;
            len_q   <= len_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tbl_q   <= tbl_d;
        end
    end

    assign bus.led   = led_w;
    assign bus.level = level_q;
    assign bus.state = state_q;
    assign bus.index = index_q;
    assign bus.done  = done_q;
endmodule
